// File: rtl/permutation_round_ctrl.sv
// Iterative ASCON permutation: one round (constant, S-box, diffusion) per clock.
// Holds the 5x64 state register and sequences p^a / p^b runs.
package permutation_round_ctrl_pkg;
  typedef logic [4:0][63:0] type_state;
endpackage

module ascon_diffusion
  import permutation_round_ctrl_pkg::*;
(
  input  type_state state_i,
  output type_state state_o
);
  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  always_comb begin
    state_o[0] = state_i[0] ^ ror(state_i[0], 19) ^ ror(state_i[0], 28);
    state_o[1] = state_i[1] ^ ror(state_i[1], 61) ^ ror(state_i[1], 39);
    state_o[2] = state_i[2] ^ ror(state_i[2], 1)  ^ ror(state_i[2], 6);
    state_o[3] = state_i[3] ^ ror(state_i[3], 10) ^ ror(state_i[3], 17);
    state_o[4] = state_i[4] ^ ror(state_i[4], 7)  ^ ror(state_i[4], 41);
  end
endmodule

module permutation_round_ctrl
  import permutation_round_ctrl_pkg::*;
#(
  parameter int unsigned ROUNDS_A = 12,
  parameter int unsigned ROUNDS_B = 6
) (
  input  logic      clock_i,
  input  logic      reset_i,
  input  logic      start_i,
  input  logic      rounds_sel_i,
  input  type_state state_i,
  output type_state state_o,
  output logic      busy_o,
  output logic      done_o
);
  if (ROUNDS_A < 1 || ROUNDS_A > 12) begin : g_bad_a
    $error("ROUNDS_A must be 1..12");
  end
  if (ROUNDS_B < 1 || ROUNDS_B > 12) begin : g_bad_b
    $error("ROUNDS_B must be 1..12");
  end

  localparam logic [3:0] CTR_A = 4'(12 - ROUNDS_A);
  localparam logic [3:0] CTR_B = 4'(12 - ROUNDS_B);
  localparam logic [3:0] CTR_LAST = 4'd11;

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

  fsm_e      fsm_q, fsm_d;
  type_state state_q, state_d;
  logic [3:0] ctr_q, ctr_d;

  type_state ca, sb, df;
  logic [63:0] a0, a1, a2, a3, a4;
  logic [63:0] t0, t1, t2, t3, t4;
  logic [63:0] b0, b1, b2, b3, b4;

  always_comb begin
    ca = state_q;
    ca[2][7:0] = state_q[2][7:0] ^ {4'd15 - ctr_q, ctr_q};
  end

  // Bit-sliced S-box: all 64 columns evaluated in parallel.
  always_comb begin
    a0 = ca[0] ^ ca[4];
    a1 = ca[1];
    a2 = ca[2] ^ ca[1];
    a3 = ca[3];
    a4 = ca[4] ^ ca[3];
    t0 = ~a0 & a1;
    t1 = ~a1 & a2;
    t2 = ~a2 & a3;
    t3 = ~a3 & a4;
    t4 = ~a4 & a0;
    b0 = a0 ^ t1;
    b1 = a1 ^ t2;
    b2 = a2 ^ t3;
    b3 = a3 ^ t4;
    b4 = a4 ^ t0;
    sb[0] = b0 ^ b4;
    sb[1] = b1 ^ b0;
    sb[2] = ~b2;
    sb[3] = b3 ^ b2;
    sb[4] = b4;
  end

  ascon_diffusion u_diff (
    .state_i (sb),
    .state_o (df)
  );

  always_comb begin
    logic accept;
    fsm_d   = fsm_q;
    state_d = state_q;
    ctr_d   = ctr_q;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    accept  = 1'b0;
    unique case (fsm_q)
      IDLE: accept = start_i;
      RUN: begin
        busy_o  = 1'b1;
        state_d = df;
        if (ctr_q == CTR_LAST) begin
          fsm_d = DONE;
        end else begin
          ctr_d = ctr_q + 4'd1;
        end
      end
      DONE: begin
        done_o = 1'b1;
        accept = start_i;
        fsm_d  = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
    // A start in DONE reloads on the same edge, so back-to-back runs need no bubble.
    if (accept) begin
      fsm_d   = RUN;
      state_d = state_i;
      ctr_d   = rounds_sel_i ? CTR_B : CTR_A;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      ctr_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      ctr_q   <= ctr_d;
    end
  end

  assign state_o = state_q;
endmodule

// File: tb/tb_permutation_round_ctrl.sv
// Bench for permutation_round_ctrl: vector table, random runs against a
// table-lookup ASCON model, plus hold-start, async reset and back-to-back cases.
module tb_permutation_round_ctrl;
  import permutation_round_ctrl_pkg::*;

  localparam int RA = 12;
  localparam int RB = 6;

  logic      clock_i = 1'b0;
  logic      reset_i = 1'b0;
  logic      start_i = 1'b0;
  logic      rounds_sel_i = 1'b0;
  type_state state_i = '0;
  type_state state_o;
  logic      busy_o;
  logic      done_o;

  int checks = 0;
  int failures = 0;

  permutation_round_ctrl #(.ROUNDS_A(RA), .ROUNDS_B(RB)) dut (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
    .start_i      (start_i),
    .rounds_sel_i (rounds_sel_i),
    .state_i      (state_i),
    .state_o      (state_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clock_i = ~clock_i;

  logic [4:0] sbox_tab [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  function automatic logic [63:0] rr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Reference permutation: the last r of the 12 ASCON rounds.
  function automatic type_state model(input type_state s0, input int r);
    type_state s, t;
    logic [4:0] v, o;
    int c;
    s = s0;
    for (int i = 12 - r; i < 12; i++) begin
      c = (15 - i) * 16 + i;
      s[2][7:0] = s[2][7:0] ^ 8'(c);
      for (int j = 0; j < 64; j++) begin
        v = {s[0][j], s[1][j], s[2][j], s[3][j], s[4][j]};
        o = sbox_tab[v];
        for (int k = 0; k < 5; k++) t[k][j] = o[4-k];
      end
      s[0] = t[0] ^ rr(t[0], 19) ^ rr(t[0], 28);
      s[1] = t[1] ^ rr(t[1], 61) ^ rr(t[1], 39);
      s[2] = t[2] ^ rr(t[2], 1)  ^ rr(t[2], 6);
      s[3] = t[3] ^ rr(t[3], 10) ^ rr(t[3], 17);
      s[4] = t[4] ^ rr(t[4], 7)  ^ rr(t[4], 41);
    end
    return s;
  endfunction

  function automatic type_state rnd_state();
    type_state s;
    for (int k = 0; k < 5; k++) s[k] = {$urandom, $urandom};
    return s;
  endfunction

  task automatic chk(input string name, input logic [319:0] act,
                     input logic [319:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Called #1 after the accepting edge; returns edges until done is visible.
  task automatic wait_done(input bit noise, output int n, output bit busy_ok);
    n = 0;
    busy_ok = 1'b1;
    forever begin
      @(negedge clock_i);
      if (done_o === 1'b1) break;
      if (busy_o !== 1'b1) busy_ok = 1'b0;
      if (noise) begin
        start_i = 1'($urandom);
        rounds_sel_i = 1'($urandom);
        state_i = rnd_state();
      end
      if (n >= 20) break;
      @(posedge clock_i);
      n++;
    end
    start_i = 1'b0;
  endtask

  task automatic run_one(input string name, input bit sel,
                         input type_state st, input bit noise);
    int n, r;
    bit bok;
    type_state exp;
    r = sel ? RB : RA;
    exp = model(st, r);
    @(negedge clock_i);
    start_i = 1'b1;
    rounds_sel_i = sel;
    state_i = st;
    @(posedge clock_i);
    #1;
    start_i = 1'b0;
    state_i = rnd_state();
    wait_done(noise, n, bok);
    chk({name, " latency"}, 320'(n), 320'(r));
    chk({name, " busy during run"}, 320'(bok), 320'(1));
    chk({name, " busy in done"}, 320'(busy_o), 320'(0));
    chk({name, " state"}, state_o, exp);
    @(negedge clock_i);
    chk({name, " done one cycle"}, 320'(done_o), 320'(0));
    chk({name, " hold"}, state_o, exp);
  endtask

  typedef struct {
    string     name;
    bit        sel;
    type_state st;
  } vec_t;

  vec_t vecs[$];
  type_state init_st, s1, s2, e1, e2;
  int n;
  bit bok, saw_done;

  initial begin
    init_st[0] = 64'h80400c0600000000;
    init_st[1] = 64'h0001020304050607;
    init_st[2] = 64'h08090a0b0c0d0e0f;
    init_st[3] = 64'h0001020304050607;
    init_st[4] = 64'h08090a0b0c0d0e0f;
    vecs.push_back('{"T1 zero pa", 1'b0, '0});
    vecs.push_back('{"T2 init pa", 1'b0, init_st});
    vecs.push_back('{"T3 init pb", 1'b1, init_st});
    vecs.push_back('{"ones pb", 1'b1, '1});

    reset_i = 1'b1;
    #12;
    chk("reset state", state_o, '0);
    chk("reset busy", 320'(busy_o), 320'(0));
    chk("reset done", 320'(done_o), 320'(0));
    @(negedge clock_i);
    reset_i = 1'b0;

    foreach (vecs[i]) run_one(vecs[i].name, vecs[i].sel, vecs[i].st, 1'b0);

    for (int i = 0; i < 12; i++)
      run_one("random", 1'($urandom), rnd_state(), 1'b1);

    // T4: start held high, state_i changing during the run is ignored.
    s1 = rnd_state();
    s2 = rnd_state();
    e1 = model(s1, RA);
    e2 = model(s2, RA);
    @(negedge clock_i);
    start_i = 1'b1;
    rounds_sel_i = 1'b0;
    state_i = s1;
    @(posedge clock_i);
    #1;
    state_i = s2;
    n = 0;
    while (done_o !== 1'b1 && n < 20) begin
      @(posedge clock_i);
      #1;
      n++;
    end
    chk("T4 first latency", 320'(n), 320'(RA));
    chk("T4 first state", state_o, e1);
    @(posedge clock_i);
    #1;
    n = 0;
    while (done_o !== 1'b1 && n < 20) begin
      @(posedge clock_i);
      #1;
      n++;
    end
    chk("T4 second latency", 320'(n), 320'(RA));
    chk("T4 second state", state_o, e2);
    start_i = 1'b0;
    @(negedge clock_i);
    chk("T4 stop", 320'(busy_o), 320'(0));

    // T5: asynchronous reset in the middle of a run.
    @(negedge clock_i);
    start_i = 1'b1;
    rounds_sel_i = 1'b0;
    state_i = rnd_state();
    @(posedge clock_i);
    #1;
    start_i = 1'b0;
    repeat (5) @(posedge clock_i);
    #2;
    reset_i = 1'b1;
    #1;
    chk("T5 reset state", state_o, '0);
    chk("T5 reset busy", 320'(busy_o), 320'(0));
    chk("T5 reset done", 320'(done_o), 320'(0));
    @(negedge clock_i);
    reset_i = 1'b0;
    saw_done = 1'b0;
    repeat (15) begin
      @(negedge clock_i);
      if (done_o === 1'b1 || busy_o === 1'b1) saw_done = 1'b1;
    end
    chk("T5 no done after reset", 320'(saw_done), 320'(0));
    run_one("T5 restart", 1'b0, init_st, 1'b0);

    // T6: second start issued during the DONE cycle.
    s1 = rnd_state();
    s2 = rnd_state();
    e1 = model(s1, RB);
    e2 = model(s2, RA);
    @(negedge clock_i);
    start_i = 1'b1;
    rounds_sel_i = 1'b1;
    state_i = s1;
    @(posedge clock_i);
    #1;
    start_i = 1'b0;
    wait_done(1'b0, n, bok);
    chk("T6 first latency", 320'(n), 320'(RB));
    chk("T6 first state", state_o, e1);
    start_i = 1'b1;
    rounds_sel_i = 1'b0;
    state_i = s2;
    @(posedge clock_i);
    #1;
    start_i = 1'b0;
    chk("T6 reload busy", 320'(busy_o), 320'(1));
    wait_done(1'b0, n, bok);
    chk("T6 second latency", 320'(n), 320'(RA));
    chk("T6 second busy", 320'(bok), 320'(1));
    chk("T6 second state", state_o, e2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
